// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings and FSM state type for the iterative ALU
package alu_pkg;
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: request/response bundle between decode operands and the iterative ALU
interface alu_iter_if #(parameter int WIDTH = 64);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             sf;
    logic             of;

    modport master(output start, op, a, b, input ready, done, result, zf, sf, of);
    modport slave(input start, op, a, b, output ready, done, result, zf, sf, of);
endinterface

// File: rtl/alu_iter_chunk_adder.sv
// chunk_adder: CHUNK-bit adder with carry in/out, reused once per RUN cycle
module chunk_adder #(parameter int CHUNK = 16) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ADD/SUB/AND/XOR, CHUNK bits per cycle, latches Y86 ZF/SF/OF on completion
module alu_iter import alu_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input logic       clk,
    input logic       rst_n,
    alu_iter_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
            $error("alu_iter: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e           state;
    alu_op_e          op_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             all_zero;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] nxt_acc;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             sf;
    logic             of;
    logic [CHUNK-1:0] sa_c;
    logic [CHUNK-1:0] sb_c;
    logic [CHUNK-1:0] sum;
    logic [CHUNK-1:0] chunk_res;
    logic             cout;
    logic             last;
    logic             zero_all;
    logic             of_n;

    assign sa_c = opa[cnt*CHUNK +: CHUNK];
    assign sb_c = opb[cnt*CHUNK +: CHUNK];

    // SUB is a + ~b with the initial carry set at acceptance
    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a    (sa_c),
        .b    (op_q == ALU_SUB ? ~sb_c : sb_c),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    assign chunk_res = op_q == ALU_AND ? sa_c & sb_c : op_q == ALU_XOR ? sa_c ^ sb_c : sum;
    assign last      = cnt == CW'(N - 1);
    assign zero_all  = all_zero & ~|chunk_res;

    always_comb begin
        nxt_acc = acc;
        nxt_acc[cnt*CHUNK +: CHUNK] = chunk_res;
    end

    assign of_n = op_q == ALU_ADD ? (opa[WIDTH-1] == opb[WIDTH-1]) && (nxt_acc[WIDTH-1] != opa[WIDTH-1])
                : op_q == ALU_SUB ? (opa[WIDTH-1] != opb[WIDTH-1]) && (nxt_acc[WIDTH-1] != opa[WIDTH-1])
                : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= ALU_ADD;
            cnt      <= '0;
            carry    <= 1'b0;
            all_zero <= 1'b1;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            result   <= '0;
            zf       <= 1'b1;
            sf       <= 1'b0;
            of       <= 1'b0;
        end else if (state == RUN) begin
            acc      <= nxt_acc;
            carry    <= cout;
            all_zero <= zero_all;
            cnt      <= cnt + 1'b1;
            if (last) begin
                state  <= DONE;
                result <= nxt_acc;
                zf     <= zero_all;
                sf     <= nxt_acc[WIDTH-1];
                of     <= of_n;
            end
        end else if (bus.start) begin
            state    <= RUN;
            op_q     <= alu_op_e'(bus.op);
            opa      <= bus.a;
            opb      <= bus.b;
            cnt      <= '0;
            carry    <= bus.op == ALU_SUB;
            all_zero <= 1'b1;
        end else begin
            state <= IDLE;
        end
    end

    assign bus.ready  = state != RUN;
    assign bus.done   = state == DONE;
    assign bus.result = result;
    assign bus.zf     = zf;
    assign bus.sf     = sf;
    assign bus.of     = of;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: randomized scoreboard bench for alu_iter against an arithmetic reference model
module tb_alu_iter;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    typedef struct {
        logic [W-1:0] r;
        logic         zf;
        logic         sf;
        logic         of;
        int           at;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_iter_if #(.WIDTH(W)) bus();
    alu_iter #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t q[$];
    int done_cycles[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed results computed in 64-bit, overflow = out of W-bit signed range
    function automatic exp_t model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        longint x = $signed(a);
        longint y = $signed(b);
        longint lim = longint'(1) <<< (W - 1);
        longint s = op == ALU_ADD ? x + y : op == ALU_SUB ? x - y : 64'sd0;
        e.r  = op == ALU_AND ? a & b : op == ALU_XOR ? a ^ b : s[W-1:0];
        e.of = (op == ALU_ADD || op == ALU_SUB) && (s >= lim || s < -lim);
        e.zf = e.r == '0;
        e.sf = e.r[W-1];
        e.at = 0;
        e.tag = "";
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {1'b0, {(W-1){1'b1}}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return '1;
            default: return $urandom;
        endcase
    endfunction

    exp_t e;
    logic [W-1:0] prev_r = '0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_r = '0;
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                chk("done_twice", prev_done, 0);
                if (q.size() == 0) chk("unexpected_done", bus.done, 0);
                else begin
                    e = q.pop_front();
                    chk({e.tag, "_result"}, bus.result, e.r);
                    chk({e.tag, "_zf"}, bus.zf, e.zf);
                    chk({e.tag, "_sf"}, bus.sf, e.sf);
                    chk({e.tag, "_of"}, bus.of, e.of);
                    chk({e.tag, "_latency"}, cyc - e.at, N);
                    done_cycles.push_back(cyc);
                end
            end else chk("result_stable", bus.result, prev_r);
            prev_r = bus.result;
            prev_done = bus.done;
        end
    end

    // Leaves start high so a following issue can be accepted back-to-back from DONE
    task automatic issue(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, string tag);
        exp_t x;
        int t = 0;
        @(negedge clk);
        while (!bus.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.ready) begin
            chk("ready_timeout", bus.ready, 1);
            return;
        end
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        x = model(op, a, b);
        x.at = cyc + 1;
        x.tag = tag;
        q.push_back(x);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic run(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, string tag);
        issue(op, a, b, tag);
        @(negedge clk);
        bus.start = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zf", bus.zf, 1);
        chk("rst_sf", bus.sf, 0);
        chk("rst_of", bus.of, 0);
        rst_n = 1'b1;

        run(ALU_SUB, 32'h7fff_ffff, 32'hffff_ffff, "sub_max_m1");
        run(ALU_SUB, 32'h8000_0000, 32'h1, "sub_min_1");
        run(ALU_SUB, 32'd9, 32'd9, "sub_eq");
        run(ALU_ADD, 32'hffff_ffff, 32'h1, "add_carry");
        run(ALU_XOR, 32'h1234, 32'h1234, "xor_eq");
        run(ALU_AND, 32'hffff_fffe, 32'd13, "and_m2_13");

        // asynchronous reset two cycles into RUN discards the operation
        issue(ALU_ADD, 32'd5, 32'd6, "rst_drop");
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.ready, 1);
        chk("midrst_result", bus.result, 0);
        chk("midrst_zf", bus.zf, 1);
        chk("midrst_sf", bus.sf, 0);
        chk("midrst_of", bus.of, 0);
        chk("midrst_done", bus.done, 0);
        q.delete();
        nd = done_cycles.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 3) @(negedge clk);
        chk("midrst_no_done", done_cycles.size(), nd);
        run(ALU_ADD, 32'd2, -32'sd13, "add_2_m13");

        // start pulsed during RUN with other operands must be ignored
        issue(ALU_SUB, 32'd100, 32'd30, "ign_run");
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = ALU_XOR;
        bus.a = 32'hdead_beef;
        bus.b = 32'h1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // start held through DONE: no idle cycle between operations
        done_cycles.delete();
        issue(ALU_ADD, 32'd1, 32'd2, "b2b0");
        issue(ALU_SUB, 32'd3, 32'd10, "b2b1");
        issue(ALU_XOR, 32'hf0f0, 32'h0ff0, "b2b2");
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        if (done_cycles.size() == 3) begin
            chk("b2b_gap0", done_cycles[1] - done_cycles[0], N + 1);
            chk("b2b_gap1", done_cycles[2] - done_cycles[1], N + 1);
        end else chk("b2b_count", done_cycles.size(), 3);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(), "rnd");
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised multi-cycle integer ALU for the Y86-64 execute stage, succeeding the fixed 32-bit combinational subtractor. Computes add, sub, and, or xor on WIDTH-bit signed operands, CHUNK bits per cycle with a carry held between cycles. Uses a start/ready/done handshake and latches the Y86 condition codes (ZF, SF, OF) on completion. Sits between decode-stage operand registers and the writeback/CC logic.

## Interface
- WIDTH, 64, operand/result width; must be a multiple of CHUNK
- CHUNK, 16, bits processed per RUN cycle; N = WIDTH/CHUNK cycles per operation
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted on a rising edge where start=1 and ready=1
- op  in  2  operation: 0 ADD (a+b), 1 SUB (a−b), 2 AND, 3 XOR
- a  in  WIDTH  signed operand A, sampled only at acceptance
- b  in  WIDTH  signed operand B, sampled only at acceptance
- ready  out  1  can accept a request (state IDLE or DONE)
- done  out  1  one-cycle pulse: result and CC are valid and updated
- result  out  WIDTH  last completed result; held until the next completion
- zf  out  1  zero flag of last completed op
- sf  out  1  sign flag (result[WIDTH-1])
- of  out  1  signed overflow flag

## Operation
- States: IDLE, RUN, DONE.
  - IDLE or DONE with start=1 → RUN; latch a, b, op; cnt=0; carry = (op==SUB).
  - IDLE or DONE with start=0 → IDLE.
  - RUN with cnt<N−1 → RUN, cnt+1.
  - RUN with cnt==N−1 → DONE.
- RUN cycle cnt processes bits [cnt*CHUNK +: CHUNK].
  - ADD: a_chunk + b_chunk + carry.
  - SUB: a_chunk + ~b_chunk + carry.
  - AND/XOR: bitwise; carry is unused.
  - The partial result and carry-out are registered. A running "all zero so far" bit is accumulated.
- On the final RUN edge, result, zf, sf and of are written together, and done=1 for exactly the following cycle (state DONE).
- OF rules, with sa=a[W−1], sb=b[W−1], sr=result[W−1]:
  - ADD: sa==sb && sr!=sa.
  - SUB: sa!=sb && sr!=sa.
  - AND/XOR: OF=0.
- Arithmetic wraps modulo 2^WIDTH. No carry flag is produced.
- start while in RUN is ignored; ready=0 during RUN. Changes on a, b or op after acceptance have no effect.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, ready=1, done=0, result=0, zf=1, sf=0, of=0, cnt=0, carry=0. The in-flight operation is discarded and CC is not updated.

## Timing
- Acceptance edge is T0. Chunks are processed on edges T1..TN. done=1 and the new result/CC are visible in the cycle after edge TN, i.e. N+1 edges after the start edge.
- ready is combinational from state (ready = state!=RUN). Back-to-back operation: start held high in DONE is accepted on that edge, giving a throughput of one op per N+1 cycles.
- result and CC change only on the completion edge or on reset; they are stable in every other cycle.
- done is never asserted for two consecutive cycles.

## Structure
- Package alu_pkg holds:
  - op encodings: ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_XOR=2'd3, matching Y86 OPq fn codes;
  - the state enum (IDLE/RUN/DONE).
- Sub-module chunk_adder: a CHUNK-bit adder with cin/cout. Instantiated once; the top-level block muxes the operand slices into it.
- Elaboration check: WIDTH % CHUNK == 0 and CHUNK ≥ 1.

## Test plan
- Config WIDTH=32, CHUNK=8, SUB, a=2147483647, b=−1 → after 5 edges done=1, result=−2147483648, of=1, sf=1, zf=0.
- Same config, SUB, a=−2147483648, b=1 → result=2147483647, of=1, sf=0. Then SUB a=9, b=9 → result=0, zf=1, of=0.
- WIDTH=64, CHUNK=16, ADD, a=0xFFFF_FFFF_FFFF_FFFF, b=1 → after 5 edges result=0, zf=1, of=0. This exercises the carry across all 4 chunks.
- WIDTH=64, XOR, a=b=0x1234 → result=0, zf=1, of=0. AND a=−2, b=13 → result=12, sf=0.
- Assert rst_n low 2 cycles into a RUN → immediately ready=1, result=0, zf=1, sf=0, of=0, and no done pulse. A following ADD 2+(−13) gives −11, sf=1.
- start pulsed in RUN with different operands → ignored, original result delivered. start held in DONE → the second op is accepted with no idle cycle, and done pulses are N+1 cycles apart.
